// File: rtl/btc_nonce_sweep_if.sv
// btc_nonce_sweep_if: bundles the sweep control inputs, the shared SHA-256
// core request/response signals and the result memory write port.
// master = the nonce sweep block, slave = its environment (top level,
// SHA core and memory).
interface btc_nonce_sweep_if;
    // Sweep control
    logic                 start;
    logic [7:0][31:0]     midstate;
    logic [2:0][31:0]     tail;
    logic [15:0]          output_addr;
    logic                 done;

    // Shared SHA-256 core
    logic                 sha_start;
    logic [15:0][31:0]    sha_message;
    logic [7:0][31:0]     sha_hin;
    logic [7:0][31:0]     sha_hout;
    logic                 sha_done;

    // Result memory write port
    logic                 mem_we;
    logic [15:0]          mem_addr;
    logic [31:0]          mem_write_data;

    modport master (
        input  start, midstate, tail, output_addr, sha_hout, sha_done,
        output done, sha_start, sha_message, sha_hin,
        mem_we, mem_addr, mem_write_data
    );

    modport slave (
        output start, midstate, tail, output_addr, sha_hout, sha_done,
        input  done, sha_start, sha_message, sha_hin,
        mem_we, mem_addr, mem_write_data
    );
endinterface

// File: rtl/btc_nonce_sweep.sv
// btc_nonce_sweep: sweeps nonces 0..NUM_NONCES-1 through the shared SHA-256
// core. For every nonce it hashes the second header block on top of the
// phase-one midstate, then hashes the resulting 256-bit digest from the
// standard IV, and keeps word 0 of the final digest.
//
// Optional build macro BTC_EARLY_WRITE_EN:
//   defined   - each result is written straight to memory in the NEXT cycle,
//               no result buffer and no write burst.
//   undefined - results are buffered and written as one burst at the end.
module btc_nonce_sweep #(
    parameter int NUM_NONCES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    btc_nonce_sweep_if.master     bus
);

    // Counter width covers 0..NUM_NONCES inclusive.
    localparam int CW = $clog2(NUM_NONCES) + 1;
    // Index width into the result buffer (at least one bit).
    localparam int IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
    localparam int DEPTH = 1 << IW;
    localparam logic [CW-1:0] LAST = CW'(NUM_NONCES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_P2_START = 3'd1;
    localparam logic [2:0] S_P2_WAIT  = 3'd2;
    localparam logic [2:0] S_P3_START = 3'd3;
    localparam logic [2:0] S_P3_WAIT  = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_WRITE    = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // SHA-256 initial hash, H0 in word 0.
    localparam logic [7:0][31:0] SHA_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    logic [2:0]          state;
    logic [CW-1:0]       n;
    logic [7:0][31:0]    mid_q;
    logic [2:0][31:0]    tail_q;
    logic [15:0]         base_q;
    logic [7:0][31:0]    digest_q;
    logic [15:0][31:0]   msg;
    logic [7:0][31:0]    hin;

`ifdef BTC_EARLY_WRITE_EN
    logic [31:0]         word_q;
`else
    logic [CW-1:0]       idx;
    logic [31:0]         result [DEPTH];
`endif

    // Sweep sequencing: latches the job, walks both hash phases per nonce
    // and hands over to the result write-out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            n        <= '0;
            mid_q    <= '0;
            tail_q   <= '0;
            base_q   <= '0;
            digest_q <= '0;
`ifdef BTC_EARLY_WRITE_EN
            word_q   <= '0;
`else
            idx      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mid_q  <= bus.midstate;
                        tail_q <= bus.tail;
                        base_q <= bus.output_addr;
                        n      <= '0;
                        state  <= S_P2_START;
                    end
                end
                S_P2_START: state <= S_P2_WAIT;
                S_P2_WAIT: begin
                    if (bus.sha_done) begin
                        digest_q <= bus.sha_hout;
                        state    <= S_P3_START;
                    end
                end
                S_P3_START: state <= S_P3_WAIT;
                S_P3_WAIT: begin
                    if (bus.sha_done) begin
`ifdef BTC_EARLY_WRITE_EN
                        word_q <= bus.sha_hout[0];
`endif
                        state  <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (n == LAST) begin
`ifdef BTC_EARLY_WRITE_EN
                        state <= S_DONE;
`else
                        idx   <= '0;
                        state <= S_WRITE;
`endif
                    end else begin
                        n     <= n + 1'b1;
                        state <= S_P2_START;
                    end
                end
                S_WRITE: begin
`ifdef BTC_EARLY_WRITE_EN
                    state <= S_IDLE;
`else
                    if (idx == LAST) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
`endif
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef BTC_EARLY_WRITE_EN
    // Result buffer: word 0 of each final digest, indexed by nonce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                result[i] <= '0;
            end
        end else if (state == S_P3_WAIT && bus.sha_done) begin
            result[n[IW-1:0]] <= bus.sha_hout[0];
        end
    end
`endif

    // Block and initial hash presented to the core; held for the whole
    // START/WAIT pair so the core may sample them at any point.
    always_comb begin
        msg = '0;
        hin = '0;
        case (state)
            S_P2_START, S_P2_WAIT: begin
                msg[0]  = tail_q[0];
                msg[1]  = tail_q[1];
                msg[2]  = tail_q[2];
                msg[3]  = 32'(n);
                msg[4]  = 32'h80000000;
                msg[15] = 32'h00000280;
                hin     = mid_q;
            end
            S_P3_START, S_P3_WAIT: begin
                msg[7:0] = digest_q;
                msg[8]   = 32'h80000000;
                msg[15]  = 32'h00000100;
                hin      = SHA_IV;
            end
            default: begin
                msg = '0;
                hin = '0;
            end
        endcase
    end

    // Memory write port: zero whenever no write is in progress.
    always_comb begin
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
`ifdef BTC_EARLY_WRITE_EN
        if (state == S_NEXT) begin
            bus.mem_we         = 1'b1;
            bus.mem_addr       = base_q + 16'(n);
            bus.mem_write_data = word_q;
        end
`else
        if (state == S_WRITE) begin
            bus.mem_we         = 1'b1;
            bus.mem_addr       = base_q + 16'(idx);
            bus.mem_write_data = result[idx[IW-1:0]];
        end
`endif
    end

    assign bus.sha_message = msg;
    assign bus.sha_hin     = hin;
    assign bus.sha_start   = (state == S_P2_START) || (state == S_P3_START);
    assign bus.done        = (state == S_DONE);

endmodule

// File: tb/tb_btc_nonce_sweep.sv
// tb_btc_nonce_sweep: drives btc_nonce_sweep with a behavioural SHA-256 core
// (fixed latency) and scores the memory writes against a double-SHA
// reference computed from the stimulus.
module tb_btc_nonce_sweep;

    localparam int N   = 16;
    localparam int LAT = 5;

    typedef logic [7:0][31:0]  h_t;
    typedef logic [15:0][31:0] blk_t;
    typedef logic [2:0][31:0]  tail_t;

    localparam h_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    btc_nonce_sweep_if bus ();

    btc_nonce_sweep #(.NUM_NONCES(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cnt_sha_start = 0;
    int cnt_we   = 0;
    int cnt_done = 0;
    int last_start_cyc = -1;
    int last_we_cyc    = -100;
    int exp_phase = 2;
    int exp_n     = 0;
    h_t    exp_mid;
    tail_t exp_tail;
    h_t    core_last_hout = '0;
    bit    hold_chk_en = 1'b1;
    logic [47:0] wq [$];

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    function automatic h_t sha_compress(input h_t h, input blk_t m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        h_t r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        end
        a = h[0]; b = h[1]; c = h[2]; d = h[3];
        e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
        r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
        return r;
    endfunction

    function automatic blk_t p2_block(input tail_t tl, input int nonce);
        blk_t blk = '0;
        blk[0]  = tl[0];
        blk[1]  = tl[1];
        blk[2]  = tl[2];
        blk[3]  = 32'(nonce);
        blk[4]  = 32'h80000000;
        blk[15] = 32'h00000280;
        return blk;
    endfunction

    function automatic blk_t p3_block(input h_t dg);
        blk_t blk = '0;
        for (int i = 0; i < 8; i++) blk[i] = dg[i];
        blk[8]  = 32'h80000000;
        blk[15] = 32'h00000100;
        return blk;
    endfunction

    function automatic logic [31:0] ref_word(input h_t mid, input tail_t tl, input int nonce);
        h_t dg, fin;
        dg  = sha_compress(mid, p2_block(tl, nonce));
        fin = sha_compress(IV, p3_block(dg));
        return fin[0];
    endfunction

    function automatic h_t rand_h();
        h_t r;
        for (int i = 0; i < 8; i++) r[i] = $urandom();
        return r;
    endfunction

    function automatic tail_t rand_tail();
        tail_t r;
        for (int i = 0; i < 3; i++) r[i] = $urandom();
        return r;
    endfunction

    // Behavioural SHA-256 core: fixed latency, hout = compress(hin, message).
    initial begin
        int   cnt;
        bit   busy;
        h_t   res;
        blk_t held_msg;
        h_t   held_hin;
        cnt = 0;
        busy = 1'b0;
        res = '0;
        held_msg = '0;
        held_hin = '0;
        bus.sha_done = 1'b0;
        bus.sha_hout = '0;
        forever begin
            @(negedge clk);
            bus.sha_done = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0;
                    bus.sha_done = 1'b1;
                    bus.sha_hout = res;
                    core_last_hout = res;
                    if (hold_chk_en) begin
                        check_val("msg_hold", bus.sha_message, held_msg);
                        check_val("hin_hold", 512'(bus.sha_hin), 512'(held_hin));
                    end
                end
            end
            if (bus.sha_start && reset_n) begin
                busy = 1'b1;
                cnt = LAT;
                held_msg = bus.sha_message;
                held_hin = bus.sha_hin;
                res = sha_compress(bus.sha_hin, bus.sha_message);
            end
        end
    end

    // Output monitor: checks every core request and scores every write.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.sha_start) begin
                cnt_sha_start++;
                if (exp_phase == 2) begin
                    check_val("p2_msg", bus.sha_message, p2_block(exp_tail, exp_n));
                    check_val("p2_hin", 512'(bus.sha_hin), 512'(exp_mid));
                    if (last_start_cyc >= 0)
                        check_val("p2_gap", 512'(cyc - last_start_cyc), 512'(LAT + 2));
                    exp_phase = 3;
                end else begin
                    check_val("p3_msg", bus.sha_message, p3_block(core_last_hout));
                    check_val("p3_hin", 512'(bus.sha_hin), 512'(IV));
                    check_val("p3_gap", 512'(cyc - last_start_cyc), 512'(LAT + 1));
                    exp_phase = 2;
                    exp_n++;
                end
                last_start_cyc = cyc;
            end
            if (bus.mem_we) begin
                cnt_we++;
                if (wq.size() == 0) begin
                    check_val("unexpected_write", 512'(bus.mem_addr), 512'(1) << 16);
                end else begin
                    e = wq.pop_front();
                    check_val("wr_addr", 512'(bus.mem_addr), 512'(e[47:32]));
                    check_val("wr_data", 512'(bus.mem_write_data), 512'(e[31:0]));
                end
                last_we_cyc = cyc;
            end
            if (bus.done) begin
                cnt_done++;
                check_val("done_after_last_write", 512'(cyc - last_we_cyc), 512'(1));
            end
        end
    end

    task automatic run_sweep(input h_t mid, input tail_t tl, input logic [15:0] base);
        int d0;
        int t;
        exp_mid = mid;
        exp_tail = tl;
        exp_n = 0;
        exp_phase = 2;
        last_start_cyc = -1;
        for (int i = 0; i < N; i++)
            wq.push_back({base + 16'(i), ref_word(mid, tl, i)});
        d0 = cnt_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.midstate = mid;
        bus.tail = tl;
        bus.output_addr = base;
        @(negedge clk);
        check_val("start_to_sha_start", 512'(bus.sha_start), 512'(1));
        // Scramble the inputs: the sweep must run on the latched copies.
        bus.start = 1'b0;
        bus.midstate = rand_h();
        bus.tail = rand_tail();
        bus.output_addr = 16'($urandom());
        t = 0;
        while (cnt_done == d0 && t < 2000) begin
            @(negedge clk);
            t++;
            bus.start = (t == 30);
        end
        bus.start = 1'b0;
        check_val("sweep_done", 512'(cnt_done != d0), 512'(1));
        repeat (5) @(negedge clk);
        check_val("done_pulse_count", 512'(cnt_done - d0), 512'(1));
        check_val("writes_drained", 512'(wq.size()), 512'(0));
        wq.delete();
    endtask

    initial begin
        int s0, w0, d0, t;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.midstate = rand_h();
        bus.tail = rand_tail();
        bus.output_addr = 16'($urandom());

        // Reset with random inputs: every output must read zero.
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'($urandom());
            bus.midstate = rand_h();
            bus.tail = rand_tail();
            bus.output_addr = 16'($urandom());
            check_val("rst_done", 512'(bus.done), 512'(0));
            check_val("rst_sha_start", 512'(bus.sha_start), 512'(0));
            check_val("rst_mem_we", 512'(bus.mem_we), 512'(0));
            check_val("rst_mem_addr", 512'(bus.mem_addr), 512'(0));
            check_val("rst_mem_data", 512'(bus.mem_write_data), 512'(0));
            check_val("rst_sha_message", bus.sha_message, 512'(0));
            check_val("rst_sha_hin", 512'(bus.sha_hin), 512'(0));
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset_n = 1'b1;

        // Idle with start low: nothing may happen.
        s0 = cnt_sha_start;
        w0 = cnt_we;
        repeat (20) @(negedge clk);
        check_val("idle_sha_start", 512'(cnt_sha_start - s0), 512'(0));
        check_val("idle_mem_we", 512'(cnt_we - w0), 512'(0));

        // Known header, results burst to 0x0100..0x010F.
        run_sweep(IV, {32'hdeadbeef, 32'h89abcdef, 32'h01234567}, 16'h0100);

        // Address wrap: 0xFFF8..0xFFFF then 0x0000..0x0007.
        run_sweep(rand_h(), rand_tail(), 16'hFFF8);

        // Reset during phase-two wait of nonce 3, stray sha_done afterwards.
        exp_mid = rand_h();
        exp_tail = rand_tail();
        exp_n = 0;
        exp_phase = 2;
        last_start_cyc = -1;
        s0 = cnt_sha_start;
        @(negedge clk);
        bus.start = 1'b1;
        bus.midstate = exp_mid;
        bus.tail = exp_tail;
        bus.output_addr = 16'h4000;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (cnt_sha_start < s0 + 7 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_val("reach_nonce3", 512'(cnt_sha_start >= s0 + 7), 512'(1));
        @(negedge clk);
        hold_chk_en = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        s0 = cnt_sha_start;
        w0 = cnt_we;
        d0 = cnt_done;
        repeat (20) @(negedge clk);
        check_val("abandon_sha_start", 512'(cnt_sha_start - s0), 512'(0));
        check_val("abandon_mem_we", 512'(cnt_we - w0), 512'(0));
        check_val("abandon_done", 512'(cnt_done - d0), 512'(0));
        hold_chk_en = 1'b1;

        // A fresh sweep after the abandoned one must complete normally.
        run_sweep(rand_h(), rand_tail(), 16'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the simulation ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
